// File: rtl/dtc_preimage_enum.sv
// Preimage enumerator: sweeps every feature vector through an attached classifier
// and streams the vectors whose predicted class matches the requested class.
module dtc_preimage_enum #(
    parameter int IN_W  = 8,
    parameter int CLS_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CLS_W-1:0] req_class,
    input  logic             abort,
    output logic [IN_W-1:0]  dt_inp,
    input  logic [CLS_W-1:0] dt_outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IN_W-1:0]  out_vec,
    output logic             done,
    output logic [IN_W:0]    match_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The producer holds valid and its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IN_W-1:0] IDX_LAST = '1;

    state_t           state, state_n;
    logic [IN_W-1:0]  idx, idx_n;
    logic [CLS_W-1:0] cls, cls_n;
    logic [IN_W:0]    cnt, cnt_n;
    logic             out_valid_n;
    logic [IN_W-1:0]  out_vec_n;
    logic [IN_W:0]    match_cnt_n;

    assign dt_inp    = idx;
    assign req_ready = (state == IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cls       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            match_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cls       <= cls_n;
            cnt       <= cnt_n;
            out_valid <= out_valid_n;
            out_vec   <= out_vec_n;
            match_cnt <= match_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cls_n       = cls;
        cnt_n       = cnt;
        out_valid_n = out_valid;
        out_vec_n   = out_vec;
        match_cnt_n = match_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cls_n   = req_class;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                // Abort wins over a hit found in the same cycle.
                if (abort) begin
                    out_valid_n = 1'b0;
                    state_n     = DONE;
                end else if (dt_outp == cls) begin
                    out_vec_n   = idx;
                    out_valid_n = 1'b1;
                    state_n     = HOLD;
                end else if (idx == IDX_LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            HOLD: begin
                // A beat accepted in the abort cycle still counts.
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    cnt_n       = cnt + 1'b1;
                end
                if (abort) begin
                    out_valid_n = 1'b0;
                    state_n     = DONE;
                end else if (out_ready) begin
                    if (idx == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = SCAN;
                    end
                end
            end
            DONE: begin
                match_cnt_n = cnt;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dtc_preimage_enum.sv
// Bench for dtc_preimage_enum: bench-side classifier, per-sweep expected queue of
// matching vectors, randomized backpressure/aborts, cycle-accurate done timing.
module tb_dtc_preimage_enum;

    localparam int IN_W  = 8;
    localparam int CLS_W = 2;
    localparam int NVEC  = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CLS_W-1:0] req_class;
    logic             abort;
    logic [IN_W-1:0]  dt_inp;
    logic [CLS_W-1:0] dt_outp;
    logic             out_valid;
    logic             out_ready;
    logic [IN_W-1:0]  out_vec;
    logic             done;
    logic [IN_W:0]    match_cnt;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // classifier behaviour: 0 = low two bits, 1 = constant 1, 2 = constant 3, 3 = random table
    int               mode = 0;
    logic [CLS_W-1:0] tbl [NVEC];

    always #5 clk = ~clk;

    dtc_preimage_enum #(.IN_W(IN_W), .CLS_W(CLS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_class (req_class),
        .abort     (abort),
        .dt_inp    (dt_inp),
        .dt_outp   (dt_outp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .done      (done),
        .match_cnt (match_cnt),
        .dbg_state (dbg_state)
    );

    assign dt_outp = (mode == 0) ? dt_inp[1:0] :
                     (mode == 1) ? 2'd1 :
                     (mode == 2) ? 2'd3 : tbl[dt_inp];

    function automatic int model_class(input int v);
        case (mode)
            0:       return v % 4;
            1:       return 1;
            2:       return 3;
            default: return int'(tbl[v]);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One sweep driven from negedges; abort_beat < 0 means never abort.
    task automatic run_sweep(input int c, input int stall_pct, input int stall_first,
                             input int abort_beat, input bit hold_req);
        logic [IN_W-1:0] exp_q[$];
        logic [IN_W-1:0] cur_vec;
        int n_exp, cycle, stalls, got, beat_cyc, busy_bad, stable_bad, abort_cyc;
        bit aborted;
        for (int v = 0; v < NVEC; v++)
            if (model_class(v) == c) exp_q.push_back(IN_W'(v));
        n_exp = exp_q.size();
        stalls = 0; got = 0; beat_cyc = 0; busy_bad = 0; stable_bad = 0;
        aborted = 0; abort_cyc = 0; cur_vec = '0;

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_class = CLS_W'(c);
        @(negedge clk);
        req_valid = hold_req;
        req_class = CLS_W'($urandom_range(0, 3));
        cycle = 1;
        check("first_dt_inp", dt_inp, 0);

        while (!done && cycle < 2000) begin
            abort     = 1'b0;
            out_ready = 1'b0;
            if (hold_req && req_ready) busy_bad++;
            if (out_valid) begin
                if (beat_cyc == 0) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("beat_vec", out_vec, exp_q[0]);
                    cur_vec = out_vec;
                end else if (out_vec !== cur_vec || dt_inp !== cur_vec) begin
                    stable_bad++;
                end
                if (got == abort_beat) begin
                    abort     = 1'b1;
                    aborted   = 1'b1;
                    abort_cyc = cycle;
                end else if (got == 0 && beat_cyc < stall_first) begin
                    out_ready = 1'b0;
                end else begin
                    out_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                if (out_ready) begin
                    got++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    beat_cyc = 0;
                end else begin
                    stalls++;
                    beat_cyc++;
                end
            end
            @(negedge clk);
            cycle++;
            if (aborted) break;
        end
        abort     = 1'b0;
        out_ready = 1'b0;

        check("done_seen", done, 1);
        check("done_not_ready", req_ready, 0);
        check("hold_stable", stable_bad, 0);
        if (aborted) begin
            check("abort_out_valid", out_valid, 0);
            check("abort_done_cycle", cycle, abort_cyc + 1);
        end else begin
            check("done_cycle", cycle, 2 * n_exp + (NVEC - n_exp) + stalls + 1);
            check("beat_count", got, n_exp);
        end
        if (hold_req) check("busy_not_ready", busy_bad, 0);

        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("match_cnt", match_cnt, got);
        check("ready_after_done", req_ready, 1);

        if (hold_req) begin
            // held request is taken on this edge; abort the new sweep in its first SCAN cycle
            @(negedge clk);
            check("held_req_accepted", req_ready, 0);
            check("held_first_dt_inp", dt_inp, 0);
            req_valid = 1'b0;
            abort     = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("scan_abort_done", done, 1);
            check("scan_abort_ov", out_valid, 0);
            @(negedge clk);
            check("scan_abort_cnt", match_cnt, 0);
        end
    endtask

    task automatic reset_mid_hold();
        int k;
        mode = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_class = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_hold_reached", out_valid, 1);
        check("rst_pre_match_cnt_nz", match_cnt != 0, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_dt_inp", dt_inp, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_out_vec", out_vec, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_class = '0; abort = 1'b0; out_ready = 1'b0;
        for (int v = 0; v < NVEC; v++) tbl[v] = CLS_W'($urandom_range(0, 3));
        repeat (3) @(negedge clk);
        check("reset_dt_inp", dt_inp, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_vec", out_vec, 0);
        check("reset_done", done, 0);
        check("reset_match_cnt", match_cnt, 0);
        check("reset_req_ready", req_ready, 1);
        rst = 1'b0;

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_done", done, 0);
        check("idle_abort_ready", req_ready, 1);

        mode = 0; run_sweep(2, 0, 0, -1, 1'b0);   // 64 hits, done at 321
        mode = 1; run_sweep(0, 0, 0, -1, 1'b0);   // no hits, done at 257
        mode = 2; run_sweep(3, 0, 0, -1, 1'b0);   // all 256 hit
        mode = 0; run_sweep(1, 0, 5, -1, 1'b0);   // backpressure on first beat
        mode = 0; run_sweep(1, 0, 0, 10, 1'b1);   // abort on 11th beat, held request

        mode = 3;
        for (int t = 0; t < 5; t++) begin
            for (int v = 0; v < NVEC; v++) tbl[v] = CLS_W'($urandom_range(0, 3));
            run_sweep($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 3),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 70) : -1, 1'b0);
        end

        reset_mid_hold();
        mode = 1; run_sweep(1, 20, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
